music_beat_sequencer: RTL and testbench
=======================================

// Module: music_beat_sequencer
// PURPOSE
//  Drives the 8-bit beat index into the per-song tone ROMs (ibeatNum -> tone) and
//  selects which song is heard. Handles play/pause, stop and next-song requests.
//  Paces beats from the system clock and mutes the audio path when not playing.
//  Sits between the debounced button pulses and the song ROM mux / tone generator.
// PARAMETERS
//  CLK_HZ        100_000_000  system clock frequency
//  BEATS_PER_SEC 8            quarter-beat rate; TICK_DIV = CLK_HZ/BEATS_PER_SEC (integer, >=2)
//  BEAT_LAST     127          last beat index of every song (<=255)
//  NUM_SONGS     2            number of songs selectable (1..4)
//  GAP_BEATS     4            silent beats between songs on auto-advance (>=1)
// PORTS
//  clk         in   1  system clock
//  rst_n       in   1  asynchronous active-low reset
//  play_pause  in   1  1-cycle pulse: toggle play/pause, start from IDLE
//  stop        in   1  1-cycle pulse: return to IDLE, beat 0
//  next_song   in   1  1-cycle pulse: advance song_sel, beat 0
//  ibeatNum    out  8  beat index to song ROMs (registered)
//  song_sel    out  2  song ROM select (registered)
//  beat_tick   out  1  1-cycle pulse on each beat advance
//  playing     out  1  1 in PLAY state
//  mute        out  1  1 = force silence downstream (any state except PLAY)
// BEHAVIOUR
//  - Reset: state=IDLE, ibeatNum=0, song_sel=0, div_cnt=0, beat_tick=0, playing=0, mute=1.
//  - States: IDLE, PLAY, PAUSE, GAP. All outputs registered; changes appear the edge after the event.
//  - Input priority when pulses coincide: stop > next_song > play_pause.
//  - div_cnt counts 0..TICK_DIV-1 only in PLAY and GAP; holds in PAUSE; cleared in IDLE,
//    on stop, on next_song, and on every IDLE->PLAY.
//  - Tick: div_cnt==TICK_DIV-1 in PLAY/GAP -> div_cnt<=0, beat_tick<=1 for one cycle.
//  - IDLE:  play_pause -> PLAY at beat 0. next_song -> song_sel+1 (wrap NUM_SONGS-1 -> 0), stay IDLE.
//  - PLAY:  tick with ibeatNum<BEAT_LAST -> ibeatNum+1. play_pause -> PAUSE (beat, div_cnt held).
//           next_song -> song_sel+1 wrapped, ibeatNum=0, stay PLAY. stop -> IDLE, ibeatNum=0.
//           tick with ibeatNum==BEAT_LAST -> song-end handling (see CONFIGURATION).
//  - PAUSE: play_pause -> PLAY resuming same beat and div_cnt. next_song -> advance, beat 0, stay PAUSE.
//           stop -> IDLE.
//  - GAP:   ibeatNum held at 0; gap counter counts ticks; after GAP_BEATS ticks -> PLAY at beat 0.
//           play_pause -> PAUSE (gap counter cleared; resume enters PLAY directly).
//           stop -> IDLE. next_song -> advance song_sel again, PLAY at beat 0.
//  - mute = (state != PLAY); playing = (state == PLAY).
//  - ibeatNum never exceeds BEAT_LAST; song_sel never reaches NUM_SONGS.
//  - Reset asserted mid-play: all state returns to reset values immediately (async).
// CONFIGURATION
//  MUSIC_AUTO_ADVANCE_EN defined: song end -> song_sel+1 wrapped, ibeatNum=0, state GAP,
//    then PLAY after GAP_BEATS ticks (continuous playlist).
//  MUSIC_AUTO_ADVANCE_EN undefined: song end -> IDLE, ibeatNum=0, song_sel unchanged;
//    GAP state unreachable (may be optimised away).
// TESTING  (CLK_HZ=80, BEATS_PER_SEC=8 -> TICK_DIV=10, BEAT_LAST=7, NUM_SONGS=2, GAP_BEATS=2)
//  1 Reset, idle 50 cycles -> ibeatNum=0, song_sel=0, mute=1, playing=0, no beat_tick.
//  2 play_pause; run 35 cycles -> playing=1, mute=0, beat_tick every 10 cycles, ibeatNum=3.
//  3 In PLAY pulse play_pause at beat 2, wait 100, pulse again -> ibeatNum stays 2 while paused,
//    next tick arrives exactly the remaining div_cnt cycles after resume.
//  4 stop+next_song+play_pause same cycle while PLAY -> IDLE, ibeatNum=0, song_sel unchanged.
//  5 next_song twice in IDLE -> song_sel 1 then 0 (wrap), state stays IDLE.
//  6 Play to beat 7 tick: AUTO_ADVANCE_EN -> song_sel=1, mute=1 for 20 cycles, then PLAY beat 0;
//    without -> IDLE, ibeatNum=0, song_sel=0, mute=1.

Source files
------------

// File: rtl/music_beat_sequencer.sv
// music_beat_sequencer: beat index / song select sequencer for the tone ROMs.
// Beats are paced by dividing the system clock. Audio is muted outside PLAY.
// Optional feature macro: MUSIC_AUTO_ADVANCE_EN
//   defined   -> at song end, go to the next song after a silent gap.
//   undefined -> at song end, return to IDLE.
module music_beat_sequencer #(
    parameter int unsigned CLK_HZ        = 100_000_000,
    parameter int unsigned BEATS_PER_SEC = 8,
    parameter int unsigned BEAT_LAST     = 127,
    parameter int unsigned NUM_SONGS     = 2,
    parameter int unsigned GAP_BEATS     = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       play_pause,
    input  logic       stop,
    input  logic       next_song,
    output logic [7:0] ibeatNum,
    output logic [1:0] song_sel,
    output logic       beat_tick,
    output logic       playing,
    output logic       mute
);

    localparam int unsigned TICK_DIV = CLK_HZ / BEATS_PER_SEC;
    localparam int unsigned DIV_W    = $clog2(TICK_DIV);
    localparam int unsigned GAP_W    = (GAP_BEATS > 1) ? $clog2(GAP_BEATS) : 1;

`ifdef MUSIC_AUTO_ADVANCE_EN
    localparam bit AUTO_ADV = 1'b1;
`else
    localparam bit AUTO_ADV = 1'b0;
`endif

    typedef enum logic [1:0] {S_IDLE, S_PLAY, S_PAUSE, S_GAP} state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [DIV_W-1:0]   r_div_cnt;
    logic [GAP_W-1:0]   r_gap_cnt;
    logic [7:0]         r_beat;
    logic [1:0]         r_song;
    logic               r_beat_tick;

    logic               w_tick;
    logic               w_any_evt;
    logic               w_beat_last;
    logic               w_gap_end;
    logic [1:0]         w_song_inc;

    assign w_tick      = ((r_state == S_PLAY) || (r_state == S_GAP)) &&
                         (r_div_cnt == DIV_W'(TICK_DIV - 1));
    assign w_any_evt   = stop | next_song | play_pause;
    assign w_beat_last = (r_beat == 8'(BEAT_LAST));
    assign w_gap_end   = (r_gap_cnt == GAP_W'(GAP_BEATS - 1));
    assign w_song_inc  = (r_song == 2'(NUM_SONGS - 1)) ? 2'd0 : r_song + 2'd1;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next-state: button pulses (stop > next_song > play_pause) override beat ticks
    always_comb begin
        w_state_nxt = r_state;
        if (stop) begin
            w_state_nxt = S_IDLE;
        end else if (next_song) begin
            if (r_state == S_GAP) w_state_nxt = S_PLAY;
        end else if (play_pause) begin
            case (r_state)
                S_IDLE:  w_state_nxt = S_PLAY;
                S_PLAY:  w_state_nxt = S_PAUSE;
                S_PAUSE: w_state_nxt = S_PLAY;
                S_GAP:   w_state_nxt = S_PAUSE;
                default: w_state_nxt = S_IDLE;
            endcase
        end else if (w_tick) begin
            if (r_state == S_PLAY && w_beat_last)
                w_state_nxt = AUTO_ADV ? S_GAP : S_IDLE;
            else if (r_state == S_GAP && w_gap_end)
                w_state_nxt = S_PLAY;
        end
    end

    // Datapath: divider, beat index, song select, gap counter and tick pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div_cnt   <= '0;
            r_gap_cnt   <= '0;
            r_beat      <= '0;
            r_song      <= '0;
            r_beat_tick <= 1'b0;
        end else begin
            // A tick coinciding with a button pulse is dropped; the pulse wins.
            r_beat_tick <= w_tick & ~w_any_evt;
            if (stop) begin
                r_div_cnt <= '0;
                r_gap_cnt <= '0;
                r_beat    <= '0;
            end else if (next_song) begin
                r_div_cnt <= '0;
                r_gap_cnt <= '0;
                r_beat    <= '0;
                r_song    <= w_song_inc;
            end else if (play_pause) begin
                // Pause/resume keep beat and divider phase; only a fresh start clears them.
                r_gap_cnt <= '0;
                if (r_state == S_IDLE) begin
                    r_div_cnt <= '0;
                    r_beat    <= '0;
                end
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_div_cnt <= '0;
                        r_gap_cnt <= '0;
                        r_beat    <= '0;
                    end
                    S_PLAY: begin
                        if (w_tick) begin
                            r_div_cnt <= '0;
                            if (w_beat_last) begin
                                r_beat <= '0;
                                if (AUTO_ADV) r_song <= w_song_inc;
                            end else begin
                                r_beat <= r_beat + 8'd1;
                            end
                        end else begin
                            r_div_cnt <= r_div_cnt + 1'b1;
                        end
                    end
                    S_GAP: begin
                        r_beat <= '0;
                        if (w_tick) begin
                            r_div_cnt <= '0;
                            r_gap_cnt <= w_gap_end ? '0 : r_gap_cnt + 1'b1;
                        end else begin
                            r_div_cnt <= r_div_cnt + 1'b1;
                        end
                    end
                    default: ; // PAUSE holds everything
                endcase
            end
        end
    end

    // Outputs decoded from registered state and datapath
    always_comb begin
        ibeatNum  = r_beat;
        song_sel  = r_song;
        beat_tick = r_beat_tick;
        playing   = (r_state == S_PLAY);
        mute      = (r_state != S_PLAY);
    end

endmodule

// File: tb/tb_music_beat_sequencer.sv
// Directed testbench for music_beat_sequencer (TICK_DIV=10, BEAT_LAST=7,
// NUM_SONGS=2, GAP_BEATS=2). Honours MUSIC_AUTO_ADVANCE_EN for song-end checks.
module tb_music_beat_sequencer;

    logic       clk;
    logic       rst_n;
    logic       play_pause;
    logic       stop;
    logic       next_song;
    logic [7:0] ibeatNum;
    logic [1:0] song_sel;
    logic       beat_tick;
    logic       playing;
    logic       mute;

    int checks   = 0;
    int failures = 0;

`ifdef MUSIC_AUTO_ADVANCE_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    music_beat_sequencer #(
        .CLK_HZ        (80),
        .BEATS_PER_SEC (8),
        .BEAT_LAST     (7),
        .NUM_SONGS     (2),
        .GAP_BEATS     (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .play_pause (play_pause),
        .stop       (stop),
        .next_song  (next_song),
        .ibeatNum   (ibeatNum),
        .song_sel   (song_sel),
        .beat_tick  (beat_tick),
        .playing    (playing),
        .mute       (mute)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    // One-cycle pulse: called at a negedge, returns at the next negedge
    task automatic pulse(input logic pp, input logic st, input logic ns);
        play_pause = pp;
        stop       = st;
        next_song  = ns;
        @(negedge clk);
        play_pause = 1'b0;
        stop       = 1'b0;
        next_song  = 1'b0;
    endtask

    task automatic test_reset;
        int nticks;
        rst_n = 1'b0; play_pause = 1'b0; stop = 1'b0; next_song = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (ibeatNum !== 8'd0) begin failures++; $display("FAIL rst_beat got=%0d exp=0", ibeatNum); end
        checks++; if (song_sel !== 2'd0) begin failures++; $display("FAIL rst_song got=%0d exp=0", song_sel); end
        checks++; if (mute !== 1'b1) begin failures++; $display("FAIL rst_mute got=%0b exp=1", mute); end
        checks++; if (playing !== 1'b0) begin failures++; $display("FAIL rst_playing got=%0b exp=0", playing); end
        rst_n = 1'b1;
        nticks = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (beat_tick === 1'b1) nticks++;
        end
        checks++; if (nticks !== 0) begin failures++; $display("FAIL idle_ticks got=%0d exp=0", nticks); end
        checks++; if (ibeatNum !== 8'd0) begin failures++; $display("FAIL idle_beat got=%0d exp=0", ibeatNum); end
        checks++; if (mute !== 1'b1) begin failures++; $display("FAIL idle_mute got=%0b exp=1", mute); end
        checks++; if (playing !== 1'b0) begin failures++; $display("FAIL idle_playing got=%0b exp=0", playing); end
    endtask

    task automatic test_play;
        pulse(1'b1, 1'b0, 1'b0);
        checks++; if (playing !== 1'b1) begin failures++; $display("FAIL play_playing got=%0b exp=1", playing); end
        checks++; if (mute !== 1'b0) begin failures++; $display("FAIL play_mute got=%0b exp=0", mute); end
        checks++; if (ibeatNum !== 8'd0) begin failures++; $display("FAIL play_beat0 got=%0d exp=0", ibeatNum); end
        for (int i = 1; i <= 35; i++) begin
            @(negedge clk);
            checks++;
            if (beat_tick !== ((i % 10) == 0)) begin
                failures++; $display("FAIL play_tick cycle=%0d got=%0b exp=%0b", i, beat_tick, (i % 10) == 0);
            end
        end
        checks++; if (ibeatNum !== 8'd3) begin failures++; $display("FAIL play_beat35 got=%0d exp=3", ibeatNum); end
    endtask

    task automatic test_pause_resume;
        int nticks;
        pulse(1'b0, 1'b1, 1'b0);
        pulse(1'b1, 1'b0, 1'b0);
        // 25 cycles into PLAY: beat 2, divider at 5
        for (int i = 1; i <= 25; i++) begin
            @(negedge clk);
            checks++;
            if (beat_tick !== ((i % 10) == 0)) begin
                failures++; $display("FAIL pre_pause_tick cycle=%0d got=%0b exp=%0b", i, beat_tick, (i % 10) == 0);
            end
        end
        checks++; if (ibeatNum !== 8'd2) begin failures++; $display("FAIL pre_pause_beat got=%0d exp=2", ibeatNum); end
        pulse(1'b1, 1'b0, 1'b0);
        checks++; if (playing !== 1'b0) begin failures++; $display("FAIL pause_playing got=%0b exp=0", playing); end
        checks++; if (mute !== 1'b1) begin failures++; $display("FAIL pause_mute got=%0b exp=1", mute); end
        nticks = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (beat_tick === 1'b1) nticks++;
        end
        checks++; if (nticks !== 0) begin failures++; $display("FAIL pause_ticks got=%0d exp=0", nticks); end
        checks++; if (ibeatNum !== 8'd2) begin failures++; $display("FAIL pause_beat got=%0d exp=2", ibeatNum); end
        pulse(1'b1, 1'b0, 1'b0);
        checks++; if (playing !== 1'b1) begin failures++; $display("FAIL resume_playing got=%0b exp=1", playing); end
        // divider resumes at 5: four increments, tick on the fifth edge
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            checks++;
            if (beat_tick !== (i == 5)) begin
                failures++; $display("FAIL resume_tick cycle=%0d got=%0b exp=%0b", i, beat_tick, i == 5);
            end
        end
        checks++; if (ibeatNum !== 8'd3) begin failures++; $display("FAIL resume_beat got=%0d exp=3", ibeatNum); end
    endtask

    task automatic test_priority;
        int nticks;
        pulse(1'b1, 1'b1, 1'b1);
        checks++; if (playing !== 1'b0) begin failures++; $display("FAIL prio_playing got=%0b exp=0", playing); end
        checks++; if (mute !== 1'b1) begin failures++; $display("FAIL prio_mute got=%0b exp=1", mute); end
        checks++; if (ibeatNum !== 8'd0) begin failures++; $display("FAIL prio_beat got=%0d exp=0", ibeatNum); end
        checks++; if (song_sel !== 2'd0) begin failures++; $display("FAIL prio_song got=%0d exp=0", song_sel); end
        nticks = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (beat_tick === 1'b1) nticks++;
        end
        checks++; if (nticks !== 0) begin failures++; $display("FAIL prio_idle_ticks got=%0d exp=0", nticks); end
        checks++; if (playing !== 1'b0) begin failures++; $display("FAIL prio_idle_playing got=%0b exp=0", playing); end
    endtask

    task automatic test_next_song_idle;
        pulse(1'b0, 1'b0, 1'b1);
        checks++; if (song_sel !== 2'd1) begin failures++; $display("FAIL next1_song got=%0d exp=1", song_sel); end
        checks++; if (playing !== 1'b0) begin failures++; $display("FAIL next1_playing got=%0b exp=0", playing); end
        pulse(1'b0, 1'b0, 1'b1);
        checks++; if (song_sel !== 2'd0) begin failures++; $display("FAIL next2_wrap got=%0d exp=0", song_sel); end
        checks++; if (mute !== 1'b1) begin failures++; $display("FAIL next2_mute got=%0b exp=1", mute); end
    endtask

    task automatic test_song_end;
        pulse(1'b1, 1'b0, 1'b0);
        for (int i = 1; i <= 80; i++) begin
            @(negedge clk);
            checks++;
            if (beat_tick !== ((i % 10) == 0)) begin
                failures++; $display("FAIL end_tick cycle=%0d got=%0b exp=%0b", i, beat_tick, (i % 10) == 0);
            end
            if (i == 79) begin
                checks++; if (ibeatNum !== 8'd7) begin failures++; $display("FAIL end_last_beat got=%0d exp=7", ibeatNum); end
            end
        end
        checks++; if (ibeatNum !== 8'd0) begin failures++; $display("FAIL end_beat got=%0d exp=0", ibeatNum); end
        checks++; if (mute !== 1'b1) begin failures++; $display("FAIL end_mute got=%0b exp=1", mute); end
        checks++; if (song_sel !== (AUTO ? 2'd1 : 2'd0)) begin
            failures++; $display("FAIL end_song got=%0d exp=%0d", song_sel, AUTO ? 1 : 0);
        end
        // Gap lasts two beats; without auto-advance the block just stays idle
        for (int i = 81; i <= 100; i++) begin
            @(negedge clk);
            if (i < 100) begin
                checks++; if (mute !== 1'b1) begin failures++; $display("FAIL gap_mute cycle=%0d got=%0b exp=1", i, mute); end
            end
        end
        checks++; if (playing !== AUTO) begin failures++; $display("FAIL gap_exit_playing got=%0b exp=%0b", playing, AUTO); end
        checks++; if (ibeatNum !== 8'd0) begin failures++; $display("FAIL gap_exit_beat got=%0d exp=0", ibeatNum); end
    endtask

    task automatic test_async_reset;
        pulse(1'b0, 1'b1, 1'b0);
        if (!AUTO) pulse(1'b0, 1'b0, 1'b1);
        checks++; if (song_sel !== 2'd1) begin failures++; $display("FAIL ares_pre_song got=%0d exp=1", song_sel); end
        pulse(1'b1, 1'b0, 1'b0);
        repeat (15) @(negedge clk);
        checks++; if (ibeatNum !== 8'd1) begin failures++; $display("FAIL ares_pre_beat got=%0d exp=1", ibeatNum); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (ibeatNum !== 8'd0) begin failures++; $display("FAIL ares_beat got=%0d exp=0", ibeatNum); end
        checks++; if (song_sel !== 2'd0) begin failures++; $display("FAIL ares_song got=%0d exp=0", song_sel); end
        checks++; if (playing !== 1'b0) begin failures++; $display("FAIL ares_playing got=%0b exp=0", playing); end
        checks++; if (mute !== 1'b1) begin failures++; $display("FAIL ares_mute got=%0b exp=1", mute); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_play();
        test_pause_resume();
        test_priority();
        test_next_song_idle();
        test_song_end();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
